ofm_read_addr_controller: RTL

Address generator for the read side of the OFM RAM. It streams a finished layer's OFM back out as row segments, either as IFM for the next layer or to the output DMA. Traversal order is column tile (outer), then row, then channel (inner). One address and segment length are issued per beat over a valid/ready handshake. It is the reader counterpart of the OFM write address controller and uses the same planar layout: each channel plane is channel_size words, row-major, ofm_size words per row.

---
 rtl/ofm_pkg.sv | 19 +
 rtl/ofm_read_addr_controller_if.sv | 14 +
 rtl/ofm_rd_loop_counter.sv | 33 +++
 rtl/ofm_read_addr_controller.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ofm_pkg.sv
// Shared definitions for the OFM read address generator: widths, FSM states, segment helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ofm_pkg;
    localparam int SYSTOLIC_SIZE = 16;
    localparam int OFM_RAM_SIZE  = 2205619;
    localparam int AW            = $clog2(OFM_RAM_SIZE);
    localparam int TW_SHIFT      = $clog2(SYSTOLIC_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [10:0] seg_len(input logic [10:0] remaining, input logic [10:0] width);
        return (remaining < width) ? remaining : width;
    endfunction
endpackage

// File: rtl/ofm_read_addr_controller_if.sv
// Read-beat bus from the OFM read address generator to its consumer.
// Latency: none (wires only).
// Backpressure: a beat holds while valid is high and ready is low.
interface ofm_read_addr_controller_if;
    import ofm_pkg::*;

    logic [AW-1:0] ofm_rd_addr;
    logic [4:0]    ofm_rd_size;
    logic          ofm_rd_valid;
    logic          ofm_rd_ready;

    modport master (output ofm_rd_addr, output ofm_rd_size, output ofm_rd_valid, input ofm_rd_ready);
    modport slave  (input ofm_rd_addr, input ofm_rd_size, input ofm_rd_valid, output ofm_rd_ready);
endinterface

// File: rtl/ofm_rd_loop_counter.sv
// Wrapping loop counter 0..max_i with a last flag, advanced by en_i and cleared by clr_i.
// Latency: count updates one cycle after en_i/clr_i.
// Backpressure: none; the caller gates en_i.
module ofm_rd_loop_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == max_i);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ofm_read_addr_controller.sv
// OFM RAM read address generator: tile/row/channel walk, one segment per beat (build option OFM_READ_UPSAMPLE_EN).
// Latency: first beat valid one cycle after start; done one cycle after the last accepted beat.
// Backpressure: valid/ready; address and size hold while valid && !ready.
module ofm_read_addr_controller
    import ofm_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [AW-1:0]              start_read_addr,
    input  logic [8:0]                 ofm_size,
    input  logic [15:0]                channel_size,
    input  logic [10:0]                num_channel,
    input  logic                       upsample_mode,
    ofm_read_addr_controller_if.master rd,
    output logic                       busy,
    output logic                       done
);
    state_t        state_q;
    logic [8:0]    ofm_size_q;
    logic [15:0]   chsize_q;
    logic [10:0]   nch_q;
    logic [5:0]    tile_max_q, tile_max_d;
    logic [AW-1:0] channel_addr_q, row_base_q, tile_base_q;
    logic          valid_q, busy_q, done_q;

    logic          start_go, accept, adv, rep_hold, last_beat;
    logic          ch_last, row_last, tile_last;
    logic [10:0]   unused_ch_cnt;
    logic [8:0]    unused_row_cnt;
    logic [5:0]    tile_cnt;
    logic [8:0]    ofm_m1;
    logic [10:0]   tw_cur, tile_off, seg_w;
    logic [4:0]    seg;
    logic [5:0]    unused_seg_hi;

    assign start_go  = start && (state_q == S_IDLE);
    assign accept    = valid_q && rd.ofm_rd_ready;
    assign adv       = accept && !rep_hold;
    assign last_beat = adv && ch_last && row_last && tile_last;
    assign ofm_m1    = ofm_size - 9'd1;

`ifdef OFM_READ_UPSAMPLE_EN
    logic up_q, rep_q;

    // First pass of a beat holds the counters; the repeat releases them.
    assign rep_hold       = up_q && !rep_q;
    assign tw_cur         = up_q ? 11'(SYSTOLIC_SIZE / 2) : 11'(SYSTOLIC_SIZE);
    assign tile_off       = up_q ? (11'(tile_cnt) << (TW_SHIFT - 1)) : (11'(tile_cnt) << TW_SHIFT);
    assign tile_max_d     = upsample_mode ? 6'(ofm_m1 >> (TW_SHIFT - 1)) : 6'(ofm_m1 >> TW_SHIFT);
    assign rd.ofm_rd_size = up_q ? (seg << 1) : seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q  <= 1'b0;
            rep_q <= 1'b0;
        end else if (start_go) begin
            up_q  <= upsample_mode;
            rep_q <= 1'b0;
        end else if (accept) begin
            rep_q <= rep_hold;
        end
    end
`else
    logic unused_upsample;

    assign unused_upsample = upsample_mode;
    assign rep_hold        = 1'b0;
    assign tw_cur          = 11'(SYSTOLIC_SIZE);
    assign tile_off        = 11'(tile_cnt) << TW_SHIFT;
    assign tile_max_d      = 6'(ofm_m1 >> TW_SHIFT);
    assign rd.ofm_rd_size  = seg;
`endif

    assign seg_w         = seg_len(11'(ofm_size_q) - tile_off, tw_cur);
    assign seg           = seg_w[4:0];
    assign unused_seg_hi = seg_w[10:5];

    ofm_rd_loop_counter #(.W(11)) u_ch_cnt (
        .clk(clk), .rst(rst), .clr_i(start_go), .en_i(adv),
        .max_i(nch_q - 11'd1), .cnt_o(unused_ch_cnt), .last_o(ch_last)
    );
    ofm_rd_loop_counter #(.W(9)) u_row_cnt (
        .clk(clk), .rst(rst), .clr_i(start_go), .en_i(adv && ch_last),
        .max_i(ofm_size_q - 9'd1), .cnt_o(unused_row_cnt), .last_o(row_last)
    );
    ofm_rd_loop_counter #(.W(6)) u_tile_cnt (
        .clk(clk), .rst(rst), .clr_i(start_go), .en_i(adv && ch_last && row_last),
        .max_i(tile_max_q), .cnt_o(tile_cnt), .last_o(tile_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ofm_size_q     <= '0;
            chsize_q       <= '0;
            nch_q          <= '0;
            tile_max_q     <= '0;
            channel_addr_q <= '0;
            row_base_q     <= '0;
            tile_base_q    <= '0;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    ofm_size_q     <= ofm_size;
                    chsize_q       <= channel_size;
                    nch_q          <= num_channel;
                    tile_max_q     <= tile_max_d;
                    channel_addr_q <= '0;
                    row_base_q     <= '0;
                    tile_base_q    <= start_read_addr;
                    busy_q         <= 1'b1;
                    if (ofm_size != '0 && num_channel != '0) begin
                        state_q <= S_ISSUE;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_ISSUE: if (adv) begin
                    channel_addr_q <= ch_last ? '0 : channel_addr_q + AW'(chsize_q);
                    if (ch_last)
                        row_base_q <= row_last ? '0 : row_base_q + AW'(ofm_size_q);
                    if (ch_last && row_last)
                        tile_base_q <= tile_base_q + AW'(tw_cur);
                    if (last_beat) begin
                        state_q <= S_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd.ofm_rd_addr  = tile_base_q + row_base_q + channel_addr_q;
    assign rd.ofm_rd_valid = valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule
